mips_multicycle_control: RTL

- Moore FSM control unit for the multi-cycle MIPS datapath.
- Sits directly upstream of the unified instruction/data memory. It drives MemRead/MemWrite and the address-select (IorD), and sequences PC, IR, register file and ALU.
- Supported opcodes: R-type (add/sub), lw, sw, beq, addi, j.
- Any other opcode is flagged and skipped.

---
 rtl/mips_pkg.sv | 71 +++++++
 rtl/mips_multicycle_control_if.sv | 40 ++++
 rtl/mips_multicycle_control.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcodes, FSM state
// encodings, datapath mux encodings and the bundled control word.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXEC    = 4'd6,
    S_RWB     = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDI_EX = 4'd9,
    S_ADDI_WB = 4'd10,
    S_JUMP    = 4'd11,
    S_HALT    = 4'd12
  } state_t;

  typedef enum logic [1:0] {
    ALU_ADD   = 2'b00,
    ALU_SUB   = 2'b01,
    ALU_FUNCT = 2'b10
  } alu_op_t;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_srcb_t;

  typedef enum logic [1:0] {
    PC_ALU    = 2'b00,
    PC_ALUOUT = 2'b01,
    PC_JUMP   = 2'b10
  } pc_src_t;

  typedef struct packed {
    logic      pc_write;
    logic      pc_write_cond;
    logic      iord;
    logic      mem_read;
    logic      mem_write;
    logic      ir_write;
    logic      memto_reg;
    logic      reg_dst;
    logic      reg_write;
    logic      alu_src_a;
    alu_srcb_t alu_src_b;
    alu_op_t   alu_op;
    pc_src_t   pc_source;
    logic      retired;
  } ctrl_t;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_J, OP_BEQ, OP_ADDI, OP_LW, OP_SW: return 1'b1;
      default:                                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_control_if.sv
// Control bus between the multi-cycle control FSM (master) and the datapath /
// unified memory (slave).
interface mips_multicycle_control_if #(
  parameter int CNT_W = 32
);

  logic [5:0]       Op;
  logic             PCWrite;
  logic             PCWriteCond;
  logic             IorD;
  logic             MemRead;
  logic             MemWrite;
  logic             IRWrite;
  logic             MemtoReg;
  logic             RegDst;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [1:0]       ALUOp;
  logic [1:0]       PCSource;
  logic [3:0]       state;
  logic             instr_retired;
  logic             illegal_op;
  logic [CNT_W-1:0] instr_count;

  modport master (
    input  Op,
    output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           state, instr_retired, illegal_op, instr_count
  );

  modport slave (
    output Op,
    input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
           MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
           state, instr_retired, illegal_op, instr_count
  );

endinterface

// File: rtl/mips_multicycle_control.sv
// Moore control FSM for the multi-cycle MIPS datapath, with a retired-instruction
// counter and illegal-opcode detection.
module mips_multicycle_control #(
  parameter int CNT_W        = 32,
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic                      clk,
  input  logic                      reset,
  mips_multicycle_control_if.master bus
);

  import mips_pkg::*;

  state_t           state_q;
  state_t           state_d;
  ctrl_t            ctrl;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EX;
          OP_J:         state_d = S_JUMP;
          default:      state_d = ILLEGAL_HALT ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR: begin
        // Op is held in IR, so only lw/sw can reach here; anything else refetches.
        if (bus.Op == OP_LW)      state_d = S_MEMRD;
        else if (bus.Op == OP_SW) state_d = S_MEMWR;
        else                      state_d = S_FETCH;
      end
      S_MEMRD:   state_d = S_MEMWB;
      S_EXEC:    state_d = S_RWB;
      S_ADDI_EX: state_d = S_ADDI_WB;
      S_HALT:    state_d = S_HALT;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.ir_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_ALU;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADR, S_ADDI_EX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.memto_reg = 1'b1;
        ctrl.retired   = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
        ctrl.retired   = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_REG;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
        ctrl.retired   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRCB_REG;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_ALUOUT;
        ctrl.retired       = 1'b1;
      end
      S_ADDI_WB: begin
        ctrl.reg_write = 1'b1;
        ctrl.retired   = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PC_JUMP;
        ctrl.retired   = 1'b1;
      end
      default: ;
    endcase
    // Reset is asynchronous, so enables must drop combinationally rather than
    // waiting for the state register to settle.
    if (reset) begin
      ctrl.pc_write      = 1'b0;
      ctrl.pc_write_cond = 1'b0;
      ctrl.mem_read      = 1'b0;
      ctrl.mem_write     = 1'b0;
      ctrl.ir_write      = 1'b0;
      ctrl.reg_write     = 1'b0;
      ctrl.retired       = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)             count_q <= '0;
    else if (ctrl.retired) count_q <= count_q + CNT_W'(1);
  end

  assign bus.PCWrite       = ctrl.pc_write;
  assign bus.PCWriteCond   = ctrl.pc_write_cond;
  assign bus.IorD          = ctrl.iord;
  assign bus.MemRead       = ctrl.mem_read;
  assign bus.MemWrite      = ctrl.mem_write;
  assign bus.IRWrite       = ctrl.ir_write;
  assign bus.MemtoReg      = ctrl.memto_reg;
  assign bus.RegDst        = ctrl.reg_dst;
  assign bus.RegWrite      = ctrl.reg_write;
  assign bus.ALUSrcA       = ctrl.alu_src_a;
  assign bus.ALUSrcB       = ctrl.alu_src_b;
  assign bus.ALUOp         = ctrl.alu_op;
  assign bus.PCSource      = ctrl.pc_source;
  assign bus.state         = state_q;
  assign bus.instr_retired = ctrl.retired;
  assign bus.illegal_op    = !reset && (state_q == S_DECODE) && !op_supported(bus.Op);
  assign bus.instr_count   = count_q;

endmodule
